// File: rtl/ram_bus_arbiter.sv
// Front-panel arbiter for the shared 6502 bus: takes the bus while the CPU is halted and runs single-byte examine/deposit accesses.
// Optional RAM_ARB_BURST_EN: chain the next request from the last HOLD cycle, keeping the grant.
module ram_bus_arbiter #(
    parameter int TURN_CYC   = 4,
    parameter int SETUP_CYC  = 3,
    parameter int ACCESS_CYC = 6,
    parameter int HOLD_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        cpu_stopped,
    input  logic        phi2_sync,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        bus_grant,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_wdata,
    output logic        bus_data_oe,
    input  logic [7:0]  bus_rdata,
    output logic        ram_cs,
    output logic        busy
);
    // A zero-length stage would never terminate the countdown, so clamp to 1.
    localparam int TURN_N   = (TURN_CYC   < 1) ? 1 : TURN_CYC;
    localparam int SETUP_N  = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int ACCESS_N = (ACCESS_CYC < 1) ? 1 : ACCESS_CYC;
    localparam int HOLD_N   = (HOLD_CYC   < 1) ? 1 : HOLD_CYC;
    localparam int MAX_A    = (TURN_N > SETUP_N) ? TURN_N : SETUP_N;
    localparam int MAX_B    = (ACCESS_N > HOLD_N) ? ACCESS_N : HOLD_N;
    localparam int MAX_N    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = (MAX_N < 2) ? 1 : $clog2(MAX_N);

    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_N - 1);
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_N - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_N - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_PH, TAKE, SETUP, ACCESS, HOLD, RELEASE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      addr_q;
    logic [7:0]       wdata_q;
    logic             write_q;
    logic             burst_ok;
    logic             accept;

`ifdef RAM_ARB_BURST_EN
    assign burst_ok = (state == HOLD) && (cnt == '0);
`else
    assign burst_ok = 1'b0;
`endif

    assign req_ready = ((state == IDLE) || burst_ok) && cpu_stopped && !rst_p;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
        end
    end

    // Bus outputs are registered from the current state, so every pin moves one edge after the state does
    // and ram_cs can never share an edge with an address/data/oe change.
    always_ff @(posedge clk) begin
        if (rst_p) begin
            state       <= IDLE;
            cnt         <= '0;
            bus_grant   <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_rw      <= 1'b1;
            bus_data_oe <= 1'b0;
            ram_cs      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            busy        <= 1'b0;
        end else begin
            bus_grant   <= state inside {TAKE, SETUP, ACCESS, HOLD};
            bus_rw      <= (state inside {TAKE, SETUP, ACCESS, HOLD}) ? !write_q : 1'b1;
            bus_data_oe <= (state inside {SETUP, ACCESS, HOLD}) && write_q;
            ram_cs      <= (state == ACCESS);
            busy        <= (state != IDLE);
            rsp_valid   <= (state == HOLD) && (cnt == HOLD_LD);
            if (state inside {TAKE, SETUP}) begin
                bus_addr  <= addr_q;
                bus_wdata <= wdata_q;
            end
            // ram_cs is still high on this edge, so bus_rdata reflects the last ACCESS cycle.
            if ((state == HOLD) && (cnt == HOLD_LD) && !write_q) begin
                rsp_rdata <= bus_rdata;
            end

            case (state)
                IDLE: begin
                    if (accept) state <= WAIT_PH;
                end
                WAIT_PH: begin
                    if (!phi2_sync) begin
                        state <= TAKE;
                        cnt   <= TURN_LD;
                    end
                end
                TAKE: begin
                    if (cnt == '0) begin
                        state <= SETUP;
                        cnt   <= SETUP_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state <= ACCESS;
                        cnt   <= ACCESS_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        if (accept) begin
                            state <= SETUP;
                            cnt   <= SETUP_LD;
                        end else begin
                            state <= RELEASE;
                            cnt   <= TURN_LD;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
